// File: rtl/frac_clk_en_gen.sv
// rtl/frac_clk_en_gen.sv - fractional NUM/DEN clock-enable generator with secondary divider and lock
module frac_clk_en_gen #(
    parameter int ACC_W       = 16,
    parameter int NUM_DEF     = 11,
    parameter int DEN_DEF     = 27,
    parameter int SDIV        = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             cfg_err,
    output logic             ce,
    output logic             ced,
    output logic             lock,
    output logic [ACC_W-1:0] cur_num,
    output logic [ACC_W-1:0] cur_den
);

    localparam int SC_W = $clog2(LOCK_CYCLES) + 1;
    localparam int CD_W = $clog2(SDIV);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(LOCK_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LAST     = CD_W'(SDIV - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum;
    logic             hit;
    logic             xfer;
    logic             legal;
    logic             load;
    logic [SC_W-1:0]  settle_cnt;
    logic [CD_W-1:0]  ce_cnt;

    // One extra bit on the sum so acc + num never wraps before the compare.
    always_comb begin
        xfer       = cfg_valid & cfg_ready;
        legal      = (cfg_den != '0) && (cfg_num != '0) && (cfg_num <= cfg_den);
        load       = xfer & legal;
        sum        = {1'b0, acc} + {1'b0, cur_num};
        hit        = (sum >= {1'b0, cur_den});
        acc_next   = hit ? ACC_W'(sum - {1'b0, cur_den}) : sum[ACC_W-1:0];
        state_next = state;
        case (state)
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = SETTLE;
        endcase
        if (load) state_next = SETTLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SETTLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
            ce         <= 1'b0;
            ced        <= 1'b0;
            lock       <= 1'b0;
            cur_num    <= ACC_W'(NUM_DEF);
            cur_den    <= ACC_W'(DEN_DEF);
            acc        <= '0;
            ce_cnt     <= '0;
            settle_cnt <= '0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= xfer & ~legal;
            if (load) begin
                // A pending ce from this edge's evaluation is intentionally dropped.
                cur_num    <= cfg_num;
                cur_den    <= cfg_den;
                acc        <= '0;
                ce_cnt     <= '0;
                settle_cnt <= '0;
                ce         <= 1'b0;
                ced        <= 1'b0;
                lock       <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
                ce         <= 1'b0;
                ced        <= 1'b0;
                lock       <= (state_next == RUN);
            end else begin
                lock <= 1'b1;
                acc  <= acc_next;
                ce   <= hit;
                if (hit) begin
                    ced    <= (ce_cnt == CD_LAST);
                    ce_cnt <= (ce_cnt == CD_LAST) ? '0 : ce_cnt + 1'b1;
                end else begin
                    ced <= 1'b0;
                end
            end
        end
    end

endmodule
